// File: rtl/pipe_perf_pkg.sv
// pipe_perf_pkg: shared types and constants for the pipeline performance monitor.
//   state_e      - monitor run state (IDLE / RUN / DONE)
//   SEL_*        - rd_sel_i encodings for counter readback
//   NUM_CNT      - number of event counters
package pipe_perf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] SEL_CYCLES  = 2'd0;
  localparam logic [1:0] SEL_STALLS  = 2'd1;
  localparam logic [1:0] SEL_FLUSHES = 2'd2;
  localparam logic [1:0] SEL_RETIRED = 2'd3;

  localparam int NUM_CNT = 4;

endpackage

// File: rtl/perf_counter.sv
// perf_counter: one event counter with synchronous clear.
// Build option: PIPE_PERF_SATURATE_EN -> saturate at all-ones and raise a
// sticky overflow flag; otherwise wrap modulo 2^CNT_W with ovf_o tied low.
// Ports:
//   clk_i  - clock
//   rst_i  - asynchronous active-low reset
//   clr_i  - synchronous clear (wins over inc_i)
//   inc_i  - increment request
//   cnt_o  - current count
//   ovf_o  - sticky overflow (saturating build only)
module perf_counter
  import pipe_perf_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o
);

  logic [CNT_W-1:0] cnt_d, cnt_q;

`ifdef PIPE_PERF_SATURATE_EN
  logic ovf_d, ovf_q;

  // An increment attempted while already all-ones is the saturating one.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (inc_i) begin
      if (&cnt_q) ovf_d = 1'b1;
      else        cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign ovf_o = ovf_q;
`else
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign ovf_o = 1'b0;
`endif

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_perf_monitor.sv
// pipe_perf_monitor: cycle-accurate performance monitor for the 5-stage core.
// Counts run cycles, true stalls (stall not caused by jump/branch), flushes
// and retired instructions while running; stops in DONE once the cycle
// counter reaches CYCLE_LIMIT (0 = never).
// Build option: PIPE_PERF_SATURATE_EN -> counters saturate, ovf_o is sticky.
// Ports:
//   clk_i, rst_i (async active-low)
//   start_i        - run enable level
//   clear_i        - synchronous clear of counters and state (highest priority)
//   stall_i, flush_i, jump_i, branch_i, retire_i - pipeline events
//   rd_sel_i       - counter select (SEL_* encodings)
//   rd_data_o      - registered readback of selected counter (pre-update value)
//   running_o      - state is RUN
//   done_o         - state is DONE
//   limit_pulse_o  - one-cycle pulse on DONE entry
//   ovf_o          - OR of per-counter sticky overflow flags
module pipe_perf_monitor
  import pipe_perf_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned CYCLE_LIMIT = 30
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             clear_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             jump_i,
  input  logic             branch_i,
  input  logic             retire_i,
  input  logic [1:0]       rd_sel_i,
  output logic [CNT_W-1:0] rd_data_o,
  output logic             running_o,
  output logic             done_o,
  output logic             limit_pulse_o,
  output logic             ovf_o
);

  // A limit the cycle counter cannot represent is treated as "no limit".
  localparam bit LIMIT_EN = (CYCLE_LIMIT != 0) &&
                            ((CNT_W >= 64) || (64'(CYCLE_LIMIT) < (64'd1 << CNT_W)));
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(CYCLE_LIMIT - 1);

`ifdef PIPE_PERF_SATURATE_EN
  if (CNT_W < 64 && 64'(CYCLE_LIMIT) >= (64'd1 << CNT_W)) begin : g_limit_chk
    $error("CYCLE_LIMIT must be below 2^CNT_W when counters saturate");
  end
`endif

  state_e state_d, state_q;
  logic   pulse_d, pulse_q;
  logic [CNT_W-1:0] rd_data_d, rd_data_q;

  logic [NUM_CNT-1:0][CNT_W-1:0] cnt;
  logic [NUM_CNT-1:0]            inc;
  logic [NUM_CNT-1:0]            cnt_ovf;
  logic                          count_en;
  logic                          limit_hit;

  assign count_en  = (state_q == RUN) && start_i && !clear_i;
  // Counter is one short of the limit, so this edge's increment lands on it.
  assign limit_hit = LIMIT_EN && (cnt[SEL_CYCLES] == LIMIT_M1);

  always_comb begin
    inc              = '0;
    inc[SEL_CYCLES]  = count_en;
    inc[SEL_STALLS]  = count_en && stall_i && !jump_i && !branch_i;
    inc[SEL_FLUSHES] = count_en && flush_i;
    inc[SEL_RETIRED] = count_en && retire_i;
  end

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
    perf_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (clear_i),
      .inc_i (inc[g]),
      .cnt_o (cnt[g]),
      .ovf_o (cnt_ovf[g])
    );
  end

  always_comb begin
    state_d   = state_q;
    pulse_d   = 1'b0;
    rd_data_d = cnt[rd_sel_i];
    if (clear_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (start_i) state_d = RUN;
        RUN: begin
          if (!start_i) begin
            state_d = IDLE;
          end else if (limit_hit) begin
            state_d = DONE;
            pulse_d = 1'b1;
          end
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      pulse_q   <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      pulse_q   <= pulse_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o     = rd_data_q;
  assign running_o     = (state_q == RUN);
  assign done_o        = (state_q == DONE);
  assign limit_pulse_o = pulse_q;
  assign ovf_o         = |cnt_ovf;

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Bench for pipe_perf_monitor: two instances (32-bit / limit 30 and
// 4-bit / no limit) share stimulus; a reference model predicts each edge's
// outputs into per-instance queues that a negedge monitor drains.
module tb_pipe_perf_monitor;

  logic clk = 1'b0;
  logic rst_i;
  logic start_i, clear_i, stall_i, flush_i, jump_i, branch_i, retire_i;
  logic [1:0] rd_sel_i;

  logic [31:0] rd_a;
  logic run_a, done_a, pulse_a, ovf_a;
  logic [3:0] rd_b;
  logic run_b, done_b, pulse_b, ovf_b;

  always #5 clk = ~clk;

  pipe_perf_monitor #(.CNT_W(32), .CYCLE_LIMIT(30)) dut_a (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .clear_i(clear_i),
    .stall_i(stall_i), .flush_i(flush_i), .jump_i(jump_i), .branch_i(branch_i),
    .retire_i(retire_i), .rd_sel_i(rd_sel_i), .rd_data_o(rd_a),
    .running_o(run_a), .done_o(done_a), .limit_pulse_o(pulse_a), .ovf_o(ovf_a));

  pipe_perf_monitor #(.CNT_W(4), .CYCLE_LIMIT(0)) dut_b (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .clear_i(clear_i),
    .stall_i(stall_i), .flush_i(flush_i), .jump_i(jump_i), .branch_i(branch_i),
    .retire_i(retire_i), .rd_sel_i(rd_sel_i), .rd_data_o(rd_b),
    .running_o(run_b), .done_o(done_b), .limit_pulse_o(pulse_b), .ovf_o(ovf_b));

`ifdef PIPE_PERF_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [31:0] rd;
    logic run;
    logic done;
    logic pulse;
    logic ovf;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  int checks = 0;
  int errors = 0;

  // Reference model: counts as plain integers, mode 0=idle 1=run 2=done.
  longint unsigned m_cnt[2][4];
  int m_mode[2];
  bit m_ovf[2];
  bit m_pulse[2];

  function automatic int mw(int d);
    return (d == 0) ? 32 : 4;
  endfunction

  function automatic longint unsigned mlim(int d);
    return (d == 0) ? 64'd30 : 64'd0;
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) m_cnt[d][i] = 0;
      m_mode[d] = 0; m_ovf[d] = 0; m_pulse[d] = 0;
    end
  endfunction

  function automatic void bump(int d, int i);
    longint unsigned mx;
    mx = (64'd1 << mw(d)) - 1;
    if (m_cnt[d][i] == mx) begin
      if (SAT) m_ovf[d] = 1'b1;
      else     m_cnt[d][i] = 0;
    end else begin
      m_cnt[d][i] = m_cnt[d][i] + 1;
    end
  endfunction

  function automatic exp_t model_edge(int d);
    exp_t e;
    e.rd = 32'(m_cnt[d][rd_sel_i]);
    m_pulse[d] = 1'b0;
    if (clear_i) begin
      for (int i = 0; i < 4; i++) m_cnt[d][i] = 0;
      m_mode[d] = 0;
      m_ovf[d]  = 1'b0;
    end else if (m_mode[d] == 1 && start_i) begin
      bump(d, 0);
      if (stall_i && !jump_i && !branch_i) bump(d, 1);
      if (flush_i)  bump(d, 2);
      if (retire_i) bump(d, 3);
      if (mlim(d) != 0 && m_cnt[d][0] == mlim(d)) begin
        m_mode[d]  = 2;
        m_pulse[d] = 1'b1;
      end
    end else if (m_mode[d] == 1) begin
      m_mode[d] = 0;
    end else if (m_mode[d] == 0 && start_i) begin
      m_mode[d] = 1;
    end
    e.run   = (m_mode[d] == 1);
    e.done  = (m_mode[d] == 2);
    e.pulse = m_pulse[d];
    e.ovf   = m_ovf[d];
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_i === 1'b1) begin
      if (q_a.size() > 0) begin
        ea = q_a.pop_front();
        check("a.rd_data", 64'(rd_a), 64'(ea.rd));
        check("a.running", 64'(run_a), 64'(ea.run));
        check("a.done", 64'(done_a), 64'(ea.done));
        check("a.limit_pulse", 64'(pulse_a), 64'(ea.pulse));
        check("a.ovf", 64'(ovf_a), 64'(ea.ovf));
      end
      if (q_b.size() > 0) begin
        eb = q_b.pop_front();
        check("b.rd_data", 64'(rd_b), 64'(eb.rd));
        check("b.running", 64'(run_b), 64'(eb.run));
        check("b.done", 64'(done_b), 64'(eb.done));
        check("b.limit_pulse", 64'(pulse_b), 64'(eb.pulse));
        check("b.ovf", 64'(ovf_b), 64'(eb.ovf));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    q_a.push_back(model_edge(0));
    q_b.push_back(model_edge(1));
    #1;
  endtask

  task automatic idle_inputs();
    start_i = 0; clear_i = 0; stall_i = 0; flush_i = 0;
    jump_i = 0; branch_i = 0; retire_i = 0; rd_sel_i = 2'd0;
  endtask

  // Asserts reset away from the clock edge and checks outputs drop at once.
  task automatic do_reset(input string tag);
    @(negedge clk); #1;
    rst_i = 1'b0;
    #1;
    check({tag, ".rst_rd_a"}, 64'(rd_a), 64'd0);
    check({tag, ".rst_run_a"}, 64'(run_a), 64'd0);
    check({tag, ".rst_done_a"}, 64'(done_a), 64'd0);
    check({tag, ".rst_pulse_a"}, 64'(pulse_a), 64'd0);
    check({tag, ".rst_ovf_a"}, 64'(ovf_a), 64'd0);
    check({tag, ".rst_rd_b"}, 64'(rd_b), 64'd0);
    check({tag, ".rst_run_b"}, 64'(run_b), 64'd0);
    idle_inputs();
    model_reset();
    q_a.delete();
    q_b.delete();
    @(negedge clk);
    rst_i = 1'b1;
  endtask

  task automatic read_sel(input logic [1:0] s);
    rd_sel_i = s;
    step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b0;
    idle_inputs();
    model_reset();
    #3;
    check("init.rd_a", 64'(rd_a), 64'd0);
    check("init.run_a", 64'(run_a), 64'd0);
    check("init.done_a", 64'(done_a), 64'd0);
    check("init.ovf_a", 64'(ovf_a), 64'd0);
    @(negedge clk);
    rst_i = 1'b1;

    // Reset mid-run
    start_i = 1; rd_sel_i = 2'd0;
    for (int i = 0; i < 11; i++) step();
    check("mid.running_before_rst", 64'(run_a), 64'd1);
    do_reset("mid");

    // Basic run: stall cycles 5-7, jump on 6
    start_i = 1; rd_sel_i = 2'd1;
    step();
    for (int c = 1; c <= 30; c++) begin
      stall_i = (c >= 5 && c <= 7);
      jump_i  = (c == 6);
      step();
    end
    stall_i = 0; jump_i = 0;
    check("basic.done_at_limit", 64'(done_a), 64'd1);
    check("basic.pulse_at_limit", 64'(pulse_a), 64'd1);
    step();
    check("basic.pulse_one_cycle", 64'(pulse_a), 64'd0);
    check("basic.done_holds", 64'(done_a), 64'd1);
    for (int i = 0; i < 5; i++) begin
      stall_i = 1; flush_i = 1; retire_i = 1;
      step();
    end
    stall_i = 0; flush_i = 0; retire_i = 0;
    read_sel(2'd0);
    check("basic.cycles", 64'(rd_a), 64'd30);
    read_sel(2'd1);
    check("basic.stalls", 64'(rd_a), 64'd2);
    read_sel(2'd3);
    check("basic.retired_frozen", 64'(rd_a), 64'd0);
    check("basic.done_after", 64'(done_a), 64'd1);
    do_reset("basic");

    // Pause
    start_i = 1; rd_sel_i = 2'd0;
    step();
    for (int i = 0; i < 8; i++) step();
    start_i = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("pause.running", 64'(run_a), 64'd0);
      check("pause.cycles_hold", 64'(rd_a), 64'd8);
    end
    start_i = 1;
    for (int i = 0; i < 60 && !done_a; i++) step();
    check("pause.done_reached", 64'(done_a), 64'd1);
    step();
    check("pause.cycles_at_done", 64'(rd_a), 64'd30);
    do_reset("pause");

    // Simultaneous stall/flush/retire
    start_i = 1;
    step();
    stall_i = 1; flush_i = 1; retire_i = 1;
    for (int i = 0; i < 3; i++) step();
    stall_i = 0; flush_i = 0; retire_i = 0;
    read_sel(2'd1);
    check("both.stalls", 64'(rd_a), 64'd3);
    read_sel(2'd2);
    check("both.flushes", 64'(rd_a), 64'd3);
    read_sel(2'd3);
    check("both.retired", 64'(rd_a), 64'd3);
    do_reset("both");

    // Clear at cycles == 12
    start_i = 1; rd_sel_i = 2'd0;
    step();
    for (int i = 0; i < 12; i++) step();
    clear_i = 1;
    step();
    check("clr.rd_pre_clear", 64'(rd_a), 64'd12);
    check("clr.running_after", 64'(run_a), 64'd0);
    check("clr.done_after", 64'(done_a), 64'd0);
    clear_i = 0;
    step();
    check("clr.rd_zero", 64'(rd_a), 64'd0);
    check("clr.rerun", 64'(run_a), 64'd1);
    do_reset("clr");

    // Narrow counter overflow: 17 retires into a 4-bit counter
    start_i = 1; retire_i = 1;
    step();
    for (int i = 0; i < 17; i++) step();
    retire_i = 0;
    read_sel(2'd3);
    check("ovf.retired_b", 64'(rd_b), SAT ? 64'd15 : 64'd1);
    check("ovf.flag_b", 64'(ovf_b), SAT ? 64'd1 : 64'd0);
    check("ovf.retired_a", 64'(rd_a), 64'd17);
    check("ovf.flag_a", 64'(ovf_a), 64'd0);
    clear_i = 1;
    step();
    clear_i = 0;
    step();
    check("ovf.flag_cleared_b", 64'(ovf_b), 64'd0);
    do_reset("ovf");

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      start_i  = ($urandom_range(0, 9) != 0);
      clear_i  = ($urandom_range(0, 39) == 0);
      stall_i  = 1'($urandom_range(0, 1));
      flush_i  = 1'($urandom_range(0, 1));
      jump_i   = ($urandom_range(0, 3) == 0);
      branch_i = ($urandom_range(0, 3) == 0);
      retire_i = 1'($urandom_range(0, 1));
      rd_sel_i = 2'($urandom_range(0, 3));
      step();
    end
    idle_inputs();
    step();
    @(negedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_perf_monitor.md
Name: pipe_perf_monitor

Overview:
- Cycle-accurate performance monitor for the 5-stage MIPS pipeline core.
- Sits downstream of the hazard-detection unit and the control unit; consumes their stall, flush, jump and branch signals plus the writeback valid bit.
- Counts run cycles, true stalls, flushes and retired instructions.
- Raises a done indication after a programmable cycle limit, so the testbench stops on a hardware event instead of its own cycle counter.

Parameters:
- CNT_W, 32: width of each counter and of rd_data_o.
- CYCLE_LIMIT, 30: run-cycle count that terminates a run. 0 means no limit; done_o never asserts.

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  asynchronous, active-low reset.
- start_i  in  1  level; run enable, same signal that drives the CPU start_i.
- clear_i  in  1  synchronous clear of all counters and state.
- stall_i  in  1  hazard-unit stall request (PC/IF-ID hold).
- flush_i  in  1  hazard-unit IF/ID flush.
- jump_i  in  1  control-unit jump decode.
- branch_i  in  1  control-unit branch decode.
- retire_i  in  1  valid instruction in WB this cycle.
- rd_sel_i  in  2  counter select: 0 cycles, 1 stalls, 2 flushes, 3 retired.
- rd_data_o  out  CNT_W  registered counter readback.
- running_o  out  1  high while in RUN.
- done_o  out  1  level; high in DONE.
- limit_pulse_o  out  1  one-cycle pulse on entry to DONE.
- ovf_o  out  1  sticky counter-overflow flag (see Optional Feature).

Behaviour:
- Reset (rst_i low, asynchronous): state IDLE; all counters 0; rd_data_o 0; running_o, done_o, limit_pulse_o, ovf_o all 0.
- States:
  - IDLE -> RUN when start_i=1.
  - RUN -> IDLE when start_i=0; counters hold (pause).
  - RUN -> DONE on the edge where the cycle counter becomes CYCLE_LIMIT.
  - DONE holds until clear_i or reset; start_i is ignored in DONE.
- Counting happens only on edges where state is RUN and start_i=1:
  - cycles +1 every such edge.
  - stalls +1 iff stall_i & ~jump_i & ~branch_i. Control-hazard holds are not counted as stalls.
  - flushes +1 iff flush_i.
  - retired +1 iff retire_i.
  - stall_i and flush_i asserted together: both counters increment.
- The IDLE->RUN transition edge does not count. The first count happens on the following edge.
- Cycle limit: the edge that makes cycles == CYCLE_LIMIT also applies that cycle's stall, flush and retire increments, enters DONE, and pulses limit_pulse_o for exactly one cycle. No counter changes afterwards.
- clear_i has priority over counting and over all transitions:
  - Next edge: counters 0, state IDLE, done_o 0, ovf_o 0.
  - If start_i is still 1 after the clear, RUN is entered on the following edge.
- Readback: rd_data_o <= counter[rd_sel_i] on every edge, giving one-cycle latency. It returns the pre-update value, so on a clear edge rd_data_o shows the pre-clear value.
- Arithmetic: unsigned, CNT_W bits. Default is wrap-around modulo 2^CNT_W.
- running_o and done_o are decoded directly from the state register. They are registered, with no combinational path from the inputs.

Optional Feature:
- Macro PIPE_PERF_SATURATE_EN.
- Defined:
  - Each counter saturates at all-ones instead of wrapping.
  - ovf_o sets on the first saturating increment and stays set until clear_i or reset.
  - The cycle counter saturating before CYCLE_LIMIT is impossible when CYCLE_LIMIT < 2^CNT_W. Elaboration error otherwise.
- Undefined: counters wrap; ovf_o is tied 0.

Decomposition:
- Package pipe_perf_pkg:
  - state enum (IDLE, RUN, DONE).
  - rd_sel encodings (SEL_CYCLES=0, SEL_STALLS=1, SEL_FLUSHES=2, SEL_RETIRED=3).
  - counter-count constant NUM_CNT=4.
- Sub-module perf_counter, instantiated 4 times:
  - Inputs: clk_i, rst_i, clr_i, inc_i.
  - Outputs: cnt_o, ovf_o.
  - Owns the wrap/saturate logic under the macro.

Test Plan:
- Reset mid-run: run 10 cycles, pulse rst_i low -> all outputs 0 immediately (asynchronous), state IDLE, rd_data_o 0.
- Basic run with CYCLE_LIMIT=30, start_i held high, stall_i high on cycles 5-7, jump_i high on cycle 6 -> after DONE: cycles=30, stalls=2, limit_pulse_o high for one cycle, done_o stays 1, counters frozen.
- Pause: run 8 cycles, drop start_i for 5 cycles, re-raise until the limit -> cycles=30 at DONE; counters unchanged during the pause; running_o 0 while paused.
- Simultaneous stall_i=1 and flush_i=1 for 3 cycles, with retire_i=1 on those same cycles -> stalls=3, flushes=3, retired=3.
- clear_i while reading rd_sel_i=0 at cycles=12 -> rd_data_o=12 on that edge, then 0; done_o 0; RUN re-entered one edge after clear_i drops if start_i=1.
- CNT_W=4, CYCLE_LIMIT=0, retire_i held for 17 cycles:
  - Macro undefined -> retired=1, ovf_o=0.
  - Macro defined -> retired=15, ovf_o=1.
